// File: rtl/uart_loader.sv
// uart_loader: serial program loader acting as bus master m2 on the xbus.
// It receives framed images on an 8N1 line: sync 0x5A, a 16-bit little-endian
// word count N, N*4 data bytes and a one-byte additive checksum. Each complete
// word is written to BASE_ADDR + 4*index. The core is stalled through
// uart_hold_o while a frame is in progress.
// Optional feature macro: UART_LOADER_ACK_EN adds tx_o, which sends 0x06 after
// a good frame and 0x15 after a failed or aborted one.
module uart_loader #(
    parameter int          CLK_DIV   = 16,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          TIMEOUT   = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_i,
    output logic [31:0] m_addr_o,
    output logic [31:0] m_data_o,
    output logic        m_we_o,
    output logic        m_req_o,
    input  logic [31:0] m_data_i,
    output logic        uart_hold_o,
    output logic        done_o,
    output logic        err_o
`ifdef UART_LOADER_ACK_EN
    ,
    output logic        tx_o
`endif
);

    localparam logic [15:0] HALF_M1 = 16'(CLK_DIV / 2 - 1);
    localparam logic [15:0] BIT_M1  = 16'(CLK_DIV - 1);
    localparam logic [31:0] TMO_M1  = 32'(TIMEOUT - 1);
    localparam logic [7:0]  SYNC    = 8'h5A;
    localparam logic [7:0]  ACK     = 8'h06;
    localparam logic [7:0]  NAK     = 8'h15;

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LEN0 = 3'd1;
    localparam logic [2:0] ST_LEN1 = 3'd2;
    localparam logic [2:0] ST_DATA = 3'd3;
    localparam logic [2:0] ST_CSUM = 3'd4;

    // Running checksum: plain sum of data bytes, modulo 256.
    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

    logic        rx_meta_r, rx_sync_r, rx_prev_r;
    logic [1:0]  rx_state_r;
    logic [15:0] rx_cnt_r;
    logic [2:0]  rx_bit_r;
    logic [7:0]  rx_shift_r;
    logic        rx_valid_r;
    logic [7:0]  rx_byte_r;
    logic        rx_ferr_r;

    logic [2:0]  state_r;
    logic [15:0] len_r;
    logic [15:0] idx_r;
    logic [31:0] word_r;
    logic [1:0]  byte_cnt_r;
    logic [7:0]  csum_r;
    logic [31:0] tmo_r;
    logic        ack_req_r;
    logic [7:0]  ack_byte_r;

    // Two-flop synchronizer plus one delayed copy for falling-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            rx_meta_r <= rx_i;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
        end
    end

    // Byte receiver: start confirm at mid-bit, eight data bits LSB first, stop check.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_r <= RX_IDLE;
            rx_cnt_r   <= 16'd0;
            rx_bit_r   <= 3'd0;
            rx_shift_r <= 8'd0;
            rx_valid_r <= 1'b0;
            rx_byte_r  <= 8'd0;
            rx_ferr_r  <= 1'b0;
        end else begin
            rx_valid_r <= 1'b0;
            rx_ferr_r  <= 1'b0;
            case (rx_state_r)
                RX_IDLE: begin
                    rx_cnt_r <= 16'd0;
                    if (rx_prev_r && !rx_sync_r) begin
                        rx_state_r <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_cnt_r == HALF_M1) begin
                        rx_cnt_r   <= 16'd0;
                        rx_bit_r   <= 3'd0;
                        // A glitch that is high again at mid-bit is not a start bit.
                        rx_state_r <= rx_sync_r ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt_r <= rx_cnt_r + 16'd1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_r == BIT_M1) begin
                        rx_cnt_r   <= 16'd0;
                        rx_shift_r <= {rx_sync_r, rx_shift_r[7:1]};
                        if (rx_bit_r == 3'd7) begin
                            rx_state_r <= RX_STOP;
                        end else begin
                            rx_bit_r <= rx_bit_r + 3'd1;
                        end
                    end else begin
                        rx_cnt_r <= rx_cnt_r + 16'd1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt_r == BIT_M1) begin
                        rx_cnt_r   <= 16'd0;
                        rx_valid_r <= rx_sync_r;
                        rx_ferr_r  <= !rx_sync_r;
                        rx_byte_r  <= rx_shift_r;
                        rx_state_r <= RX_IDLE;
                    end else begin
                        rx_cnt_r <= rx_cnt_r + 16'd1;
                    end
                end
                default: rx_state_r <= RX_IDLE;
            endcase
        end
    end

    // Frame parser, word assembly, bus write strobe, status flags and timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            len_r       <= 16'd0;
            idx_r       <= 16'd0;
            word_r      <= 32'd0;
            byte_cnt_r  <= 2'd0;
            csum_r      <= 8'd0;
            tmo_r       <= 32'd0;
            m_addr_o    <= 32'd0;
            m_data_o    <= 32'd0;
            m_we_o      <= 1'b0;
            m_req_o     <= 1'b0;
            uart_hold_o <= 1'b0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
            ack_req_r   <= 1'b0;
            ack_byte_r  <= 8'd0;
        end else begin
            m_req_o   <= 1'b0;
            m_we_o    <= 1'b0;
            ack_req_r <= 1'b0;
            if (state_r == ST_IDLE) begin
                tmo_r <= 32'd0;
                if (rx_valid_r && (rx_byte_r == SYNC)) begin
                    state_r     <= ST_LEN0;
                    uart_hold_o <= 1'b1;
                    done_o      <= 1'b0;
                    err_o       <= 1'b0;
                    idx_r       <= 16'd0;
                    csum_r      <= 8'd0;
                    byte_cnt_r  <= 2'd0;
                end
            end else if (rx_ferr_r || (!rx_valid_r && (tmo_r == TMO_M1))) begin
                // Abort: words already written stay, the partial word is dropped.
                state_r     <= ST_IDLE;
                uart_hold_o <= 1'b0;
                done_o      <= 1'b0;
                err_o       <= 1'b1;
                tmo_r       <= 32'd0;
                ack_req_r   <= 1'b1;
                ack_byte_r  <= NAK;
            end else if (rx_valid_r) begin
                tmo_r <= 32'd0;
                case (state_r)
                    ST_LEN0: begin
                        len_r[7:0] <= rx_byte_r;
                        state_r    <= ST_LEN1;
                    end
                    ST_LEN1: begin
                        len_r[15:8] <= rx_byte_r;
                        state_r     <= ({rx_byte_r, len_r[7:0]} == 16'd0) ? ST_CSUM : ST_DATA;
                    end
                    ST_DATA: begin
                        // Little-endian: each new byte enters at the top and shifts down.
                        word_r     <= {rx_byte_r, word_r[31:8]};
                        csum_r     <= csum_add(csum_r, rx_byte_r);
                        byte_cnt_r <= byte_cnt_r + 2'd1;
                        if (byte_cnt_r == 2'd3) begin
                            m_req_o  <= 1'b1;
                            m_we_o   <= 1'b1;
                            m_addr_o <= BASE_ADDR + {14'd0, idx_r, 2'b00};
                            m_data_o <= {rx_byte_r, word_r[31:8]};
                            idx_r    <= idx_r + 16'd1;
                            if (idx_r == (len_r - 16'd1)) begin
                                state_r <= ST_CSUM;
                            end
                        end
                    end
                    ST_CSUM: begin
                        state_r     <= ST_IDLE;
                        uart_hold_o <= 1'b0;
                        done_o      <= (rx_byte_r == csum_r);
                        err_o       <= (rx_byte_r != csum_r);
                        ack_req_r   <= 1'b1;
                        ack_byte_r  <= (rx_byte_r == csum_r) ? ACK : NAK;
                    end
                    default: state_r <= ST_IDLE;
                endcase
            end else begin
                tmo_r <= tmo_r + 32'd1;
            end
        end
    end

`ifdef UART_LOADER_ACK_EN
    logic [8:0]  tx_shift_r;
    logic [15:0] tx_cnt_r;
    logic [3:0]  tx_left_r;
    logic        tx_r;
    logic        unused_s;

    assign unused_s = ^m_data_i;
    assign tx_o     = tx_r;

    // Acknowledge transmitter; a new request restarts it even mid-character.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_r       <= 1'b1;
            tx_shift_r <= 9'h1FF;
            tx_cnt_r   <= 16'd0;
            tx_left_r  <= 4'd0;
        end else if (ack_req_r) begin
            tx_r       <= 1'b0;
            tx_shift_r <= {1'b1, ack_byte_r};
            tx_cnt_r   <= 16'd0;
            tx_left_r  <= 4'd9;
        end else if (tx_left_r != 4'd0) begin
            if (tx_cnt_r == BIT_M1) begin
                tx_cnt_r   <= 16'd0;
                tx_r       <= tx_shift_r[0];
                tx_shift_r <= {1'b1, tx_shift_r[8:1]};
                tx_left_r  <= tx_left_r - 4'd1;
            end else begin
                tx_cnt_r <= tx_cnt_r + 16'd1;
            end
        end else begin
            tx_r <= 1'b1;
        end
    end
`else
    logic unused_s;
    assign unused_s = ^{m_data_i, ack_req_r, ack_byte_r};
`endif

endmodule
